// File: rtl/pc_stack_seq.sv
// Sequencer program counter with jump, relative branch, call/return stack
// and sticky end-of-space / stack-error flags.
module pc_stack_seq #(
    parameter int unsigned           WIDTH       = 5,
    parameter logic [WIDTH-1:0]      RESET_VEC   = '0,
    parameter bit                    WRAP_MODE   = 1'b0,
    parameter int unsigned           STACK_DEPTH = 4,
    parameter int unsigned           DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] pc,
    output logic             max_reached,
    output logic             stack_err,
    output logic             stack_full,
    output logic             stack_empty,
    output logic [DW-1:0]    depth
);

    localparam int unsigned      AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [WIDTH-1:0] MAX = '1;

    localparam logic [2:0] OpHold   = 3'b000;
    localparam logic [2:0] OpInc    = 3'b001;
    localparam logic [2:0] OpJump   = 3'b010;
    localparam logic [2:0] OpBranch = 3'b011;
    localparam logic [2:0] OpCall   = 3'b100;
    localparam logic [2:0] OpRet    = 3'b101;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             max_q, max_d;
    logic             err_q, err_d;
    logic             push, max_set, err_set;
    logic [AW-1:0]    push_idx, pop_idx;
    logic [DW-1:0]    depth_m1;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign depth_m1    = depth_q - DW'(1);
    assign push_idx    = depth_q[AW-1:0];
    assign pop_idx     = depth_m1[AW-1:0];

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        max_set = 1'b0;
        err_set = 1'b0;
        if (en) begin
            case (op)
                OpInc: begin
                    if (pc_q == MAX) begin
                        max_set = 1'b1;
                        if (WRAP_MODE) pc_d = '0;
                    end else begin
                        pc_d = pc_q + WIDTH'(1);
                    end
                end
                OpJump: pc_d = operand;
                // Modular add of equal widths is the same as adding the sign-extended offset.
                OpBranch: pc_d = pc_q + operand;
                OpCall: begin
                    if (stack_full) begin
                        err_set = 1'b1;
                    end else begin
                        push    = 1'b1;
                        depth_d = depth_q + DW'(1);
                        pc_d    = operand;
                    end
                end
                OpRet: begin
                    if (stack_empty) begin
                        err_set = 1'b1;
                    end else begin
                        pc_d    = stack_q[pop_idx];
                        depth_d = depth_m1;
                    end
                end
                default: ;
            endcase
        end
        // A new set event wins over a simultaneous clear.
        max_d = max_set | (max_q & ~clr_flags);
        err_d = err_set | (err_q & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            max_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            max_q   <= max_d;
            err_q   <= err_d;
        end
    end

    // Entries above depth are never read, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= pc_q + WIDTH'(1);
    end

    assign pc          = pc_q;
    assign depth       = depth_q;
    assign max_reached = max_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Scoreboard bench for pc_stack_seq: a saturating default instance and a
// wrapping instance, driven by directed vectors with hand-computed results.
module tb_pc_stack_seq;

    localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JUMP = 3'b010;
    localparam logic [2:0] BRANCH = 3'b011, CALL = 3'b100, RET = 3'b101, RSVD = 3'b110;

    typedef struct {
        bit         sel;
        logic [4:0] pc;
        logic       mx;
        logic       er;
        logic [2:0] dp;
        int         id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, clr = 1'b0, w_en = 1'b0, w_clr = 1'b0;
    logic [2:0] op = HOLD, w_op = HOLD;
    logic [4:0] operand = '0, w_operand = '0;
    logic [4:0] pc, w_pc;
    logic       mx, er, full, empty, w_mx, w_er, w_full, w_empty;
    logic [2:0] dp, w_dp;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step = 0;

    always #5 clk = ~clk;

    pc_stack_seq dut (
        .clk(clk), .rstn(rstn), .en(en), .op(op), .operand(operand), .clr_flags(clr),
        .pc(pc), .max_reached(mx), .stack_err(er), .stack_full(full),
        .stack_empty(empty), .depth(dp)
    );

    pc_stack_seq #(.WRAP_MODE(1'b1)) dut_w (
        .clk(clk), .rstn(rstn), .en(w_en), .op(w_op), .operand(w_operand),
        .clr_flags(w_clr), .pc(w_pc), .max_reached(w_mx), .stack_err(w_er),
        .stack_full(w_full), .stack_empty(w_empty), .depth(w_dp)
    );

    task automatic chk(input string nm, input int id, input logic [7:0] act,
                       input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, id, act, want);
        end
    endtask

    // Inputs change on the falling edge; the expectation covers the next rising edge.
    task automatic drive(input bit s, input logic [2:0] o, input logic [4:0] opd,
                         input logic e, input logic c, input logic [4:0] xp,
                         input logic xm, input logic xe, input logic [2:0] xd);
        exp_t x;
        @(negedge clk);
        en = 1'b0; op = HOLD; clr = 1'b0; w_en = 1'b0; w_op = HOLD; w_clr = 1'b0;
        if (!s) begin
            en = e; op = o; operand = opd; clr = c;
        end else begin
            w_en = e; w_op = o; w_operand = opd; w_clr = c;
        end
        x.sel = s; x.pc = xp; x.mx = xm; x.er = xe; x.dp = xd; x.id = step;
        exp_q.push_back(x);
        step++;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; op = HOLD; clr = 1'b0; w_en = 1'b0; w_op = HOLD; w_clr = 1'b0;
    endtask

    // Monitor: the DUT presents a new result one rising edge after each issued op.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                if (!x.sel) begin
                    chk("pc", x.id, 8'(pc), 8'(x.pc));
                    chk("max_reached", x.id, 8'(mx), 8'(x.mx));
                    chk("stack_err", x.id, 8'(er), 8'(x.er));
                    chk("depth", x.id, 8'(dp), 8'(x.dp));
                    chk("stack_full", x.id, 8'(full), 8'(x.dp == 3'd4));
                    chk("stack_empty", x.id, 8'(empty), 8'(x.dp == 3'd0));
                end else begin
                    chk("w_pc", x.id, 8'(w_pc), 8'(x.pc));
                    chk("w_max_reached", x.id, 8'(w_mx), 8'(x.mx));
                    chk("w_stack_err", x.id, 8'(w_er), 8'(x.er));
                    chk("w_depth", x.id, 8'(w_dp), 8'(x.dp));
                end
            end
        end
    end

    initial begin
        #12;
        chk("reset_pc", -1, 8'(pc), 8'd0);
        chk("reset_flags", -1, {6'd0, mx, er}, 8'd0);
        chk("reset_depth", -1, 8'(dp), 8'd0);
        chk("reset_empty_full", -1, {6'd0, empty, full}, 8'b10);
        @(negedge clk);
        rstn = 1'b1;

        // Count up to MAX, then saturate.
        for (int i = 0; i < 31; i++) drive(0, INC, 5'd0, 1, 0, 5'(i + 1), 0, 0, 3'd0);
        drive(0, INC, 5'd0, 1, 0, 5'd31, 1, 0, 3'd0);
        drive(0, INC, 5'd0, 1, 0, 5'd31, 1, 0, 3'd0);
        drive(0, HOLD, 5'd0, 1, 1, 5'd31, 0, 0, 3'd0);

        // Stall and reserved op.
        drive(0, JUMP, 5'd3, 1, 0, 5'd3, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) drive(0, INC, 5'd0, 0, 0, 5'd3, 0, 0, 3'd0);
        drive(0, RSVD, 5'd9, 1, 0, 5'd3, 0, 0, 3'd0);

        // Relative branches wrap and never flag.
        drive(0, BRANCH, 5'b11110, 1, 0, 5'd1, 0, 0, 3'd0);
        drive(0, JUMP, 5'd30, 1, 0, 5'd30, 0, 0, 3'd0);
        drive(0, BRANCH, 5'd5, 1, 0, 5'd3, 0, 0, 3'd0);

        // Nested call/return.
        drive(0, JUMP, 5'd10, 1, 0, 5'd10, 0, 0, 3'd0);
        drive(0, CALL, 5'd20, 1, 0, 5'd20, 0, 0, 3'd1);
        drive(0, CALL, 5'd25, 1, 0, 5'd25, 0, 0, 3'd2);
        drive(0, RET, 5'd0, 1, 0, 5'd21, 0, 0, 3'd1);
        drive(0, RET, 5'd0, 1, 0, 5'd11, 0, 0, 3'd0);

        // Underflow; set beats clear; clear alone.
        drive(0, RET, 5'd0, 1, 0, 5'd11, 0, 1, 3'd0);
        drive(0, RET, 5'd0, 1, 1, 5'd11, 0, 1, 3'd0);
        drive(0, HOLD, 5'd0, 1, 1, 5'd11, 0, 0, 3'd0);

        // Fill, overflow, then unwind in reverse order.
        drive(0, CALL, 5'd1, 1, 0, 5'd1, 0, 0, 3'd1);
        drive(0, CALL, 5'd2, 1, 0, 5'd2, 0, 0, 3'd2);
        drive(0, CALL, 5'd3, 1, 0, 5'd3, 0, 0, 3'd3);
        drive(0, CALL, 5'd4, 1, 0, 5'd4, 0, 0, 3'd4);
        drive(0, CALL, 5'd5, 1, 0, 5'd4, 0, 1, 3'd4);
        drive(0, RET, 5'd0, 1, 0, 5'd4, 0, 1, 3'd3);
        drive(0, RET, 5'd0, 1, 0, 5'd3, 0, 1, 3'd2);
        drive(0, RET, 5'd0, 1, 0, 5'd2, 0, 1, 3'd1);
        drive(0, RET, 5'd0, 1, 0, 5'd12, 0, 1, 3'd0);

        // Return address wraps past MAX.
        drive(0, JUMP, 5'd31, 1, 0, 5'd31, 0, 1, 3'd0);
        drive(0, CALL, 5'd7, 1, 0, 5'd7, 0, 1, 3'd1);
        drive(0, RET, 5'd0, 1, 0, 5'd0, 0, 1, 3'd0);

        // Clear is honoured while stalled.
        drive(0, INC, 5'd0, 0, 1, 5'd0, 0, 0, 3'd0);

        // Wrapping instance.
        drive(1, JUMP, 5'd31, 1, 0, 5'd31, 0, 0, 3'd0);
        drive(1, INC, 5'd0, 1, 0, 5'd0, 1, 0, 3'd0);
        drive(1, HOLD, 5'd0, 1, 0, 5'd0, 1, 0, 3'd0);
        drive(1, HOLD, 5'd0, 1, 1, 5'd0, 0, 0, 3'd0);
        drive(1, JUMP, 5'd30, 1, 0, 5'd30, 0, 0, 3'd0);
        drive(1, BRANCH, 5'd5, 1, 0, 5'd3, 0, 0, 3'd0);

        // Asynchronous reset between clock edges.
        drive(0, JUMP, 5'd9, 1, 0, 5'd9, 0, 0, 3'd0);
        drive(0, CALL, 5'd15, 1, 0, 5'd15, 0, 0, 3'd1);
        idle();
        #2;
        rstn = 1'b0;
        #1;
        chk("async_pc", step, 8'(pc), 8'd0);
        chk("async_depth", step, 8'(dp), 8'd0);
        chk("async_empty", step, 8'(empty), 8'd1);
        @(negedge clk);
        rstn = 1'b1;
        drive(0, INC, 5'd0, 1, 0, 5'd1, 0, 0, 3'd0);
        idle();

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
